// File: rtl/ecr_file.sv
// rtl/ecr_file.sv - branch-resolution ECR state file with rollback, allocation and predictor training
module ecr_file #(
  parameter  int NUM_ECRS = 2,
  parameter  int NUM_SICS = 4,
  localparam int ECR_W    = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_wen,
  input  logic [ECR_W-1:0]  upd_addr,
  input  logic              upd_do_reset,
  input  logic [1:0]        upd_reset_data,
  input  logic              upd_do_bpinfo,
  input  logic [31:0]       upd_bpinfo_pc,
  input  logic              upd_bpinfo_pred_taken,
  input  logic              upd_do_altpc,
  input  logic [31:0]       upd_altpc_pc,
  input  logic              sic_res_valid [NUM_SICS],
  input  logic [ECR_W-1:0]  sic_res_ecr   [NUM_SICS],
  input  logic              sic_res_taken [NUM_SICS],
  input  logic              sic_dep_valid [NUM_SICS],
  input  logic [1:0]        sic_dep_ecr   [NUM_SICS],
  output logic              alloc_avail,
  output logic [ECR_W-1:0]  alloc_id,
  output logic              rollback_valid,
  output logic [ECR_W-1:0]  rollback_id,
  output logic [31:0]       rollback_target_pc,
  output logic              in_use        [NUM_ECRS],
  output logic [1:0]        ecr_monitor   [NUM_ECRS],
  output logic              bp_upd_valid,
  output logic [31:0]       bp_upd_pc,
  output logic              bp_upd_taken
);

  typedef enum logic [1:0] {
    PEND = 2'b00,
    DONE = 2'b01,
    MISP = 2'b10
  } ecr_state_e;

  ecr_state_e  state     [NUM_ECRS];
  ecr_state_e  nstate    [NUM_ECRS];
  logic [31:0] pc        [NUM_ECRS];
  logic [31:0] altpc     [NUM_ECRS];
  logic        pred      [NUM_ECRS];
  logic        applied   [NUM_ECRS];
  logic        res_taken [NUM_ECRS];
  logic        ack;
  logic        train_valid;
  logic        train_taken;
  logic [31:0] train_pc;

  always_comb begin
    for (int e = 0; e < NUM_ECRS; e++) begin
      in_use[e] = 1'b0;
      ecr_monitor[e] = state[e];
      for (int s = 0; s < NUM_SICS; s++)
        if (sic_dep_valid[s] && int'(sic_dep_ecr[s]) == e) in_use[e] = 1'b1;
    end
  end

  // Descending scans so the lowest matching index is the last one assigned.
  always_comb begin
    alloc_avail        = 1'b0;
    alloc_id           = '0;
    rollback_valid     = 1'b0;
    rollback_id        = '0;
    rollback_target_pc = '0;
    for (int e = NUM_ECRS - 1; e >= 0; e--) begin
      if (state[e] == DONE && !in_use[e]) begin
        alloc_avail = 1'b1;
        alloc_id    = ECR_W'(e);
      end
      if (state[e] == MISP) begin
        rollback_valid     = 1'b1;
        rollback_id        = ECR_W'(e);
        rollback_target_pc = altpc[e];
      end
    end
  end

  assign ack = upd_wen && upd_do_reset && upd_reset_data == 2'b01 &&
               rollback_valid && upd_addr == rollback_id;

  // A resolution lands only on a PEND entry that is neither re-seeded by issue nor flushed.
  always_comb begin
    for (int e = 0; e < NUM_ECRS; e++) begin
      logic hit;
      hit          = 1'b0;
      res_taken[e] = 1'b0;
      for (int s = NUM_SICS - 1; s >= 0; s--)
        if (sic_res_valid[s] && int'(sic_res_ecr[s]) == e) begin
          hit          = 1'b1;
          res_taken[e] = sic_res_taken[s];
        end
      applied[e] = hit && state[e] == PEND && !ack &&
                   !(upd_wen && upd_do_reset && int'(upd_addr) == e);
      nstate[e] = state[e];
      if (applied[e])
        nstate[e] = (res_taken[e] == pred[e]) ? DONE : MISP;
      if (ack)
        nstate[e] = DONE;
      if (upd_wen && upd_do_reset && int'(upd_addr) == e)
        nstate[e] = (upd_reset_data == 2'b11) ? DONE : ecr_state_e'(upd_reset_data);
    end
  end

  // The lowest SIC whose ECR accepts a resolution is necessarily the lowest for that ECR.
  always_comb begin
    train_valid = 1'b0;
    train_taken = 1'b0;
    train_pc    = '0;
    for (int s = NUM_SICS - 1; s >= 0; s--)
      for (int e = 0; e < NUM_ECRS; e++)
        if (sic_res_valid[s] && int'(sic_res_ecr[s]) == e && applied[e]) begin
          train_valid = 1'b1;
          train_taken = sic_res_taken[s];
          train_pc    = pc[e];
        end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ECRS; e++) begin
        state[e] <= DONE;
        pc[e]    <= '0;
        altpc[e] <= '0;
        pred[e]  <= 1'b0;
      end
      bp_upd_valid <= 1'b0;
      bp_upd_pc    <= '0;
      bp_upd_taken <= 1'b0;
    end else begin
      for (int e = 0; e < NUM_ECRS; e++) begin
        state[e] <= nstate[e];
        if (upd_wen && int'(upd_addr) == e) begin
          if (upd_do_bpinfo) begin
            pc[e]   <= upd_bpinfo_pc;
            pred[e] <= upd_bpinfo_pred_taken;
          end
          if (upd_do_altpc) altpc[e] <= upd_altpc_pc;
        end
      end
      bp_upd_valid <= train_valid;
      if (train_valid) begin
        bp_upd_pc    <= train_pc;
        bp_upd_taken <= train_taken;
      end
    end
  end

endmodule
